// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_arb_pkg;

    localparam int BURST_LEN_DEF = 2;
    localparam int AW_DEF        = 30;
    localparam int DW_DEF        = 32;

    typedef enum logic [1:0] {
        IDLE,
        IC_RD,
        DC_RD,
        DC_WR
    } arb_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the I-side and the D-side.
// The only state is the side granted last; a tie goes to the other side.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ic_req,
    input  logic dc_req,
    output logic ic_gnt,
    output logic dc_gnt
);

    owner_t rr_last;

    // Grant decision: a lone requester wins, a tie goes to the side not granted last.
    always_comb begin
        ic_gnt = 1'b0;
        dc_gnt = 1'b0;
        if (en) begin
            if (ic_req && (!dc_req || rr_last == OWN_DC)) begin
                ic_gnt = 1'b1;
            end else if (dc_req) begin
                dc_gnt = 1'b1;
            end
        end
    end

    // Remember the last granted side; reset favours the I-side on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= OWN_DC;
        end else if (ic_gnt) begin
            rr_last <= OWN_IC;
        end else if (dc_gnt) begin
            rr_last <= OWN_DC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the I-cache refill engine and
// the D-cache miss/writeback engine, issuing each transaction as a burst of
// BURST_LEN word beats. Read beats are forwarded to the owner with zero latency.
// Optional build macro MEM_ARB_PERF_CNT_EN adds three performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ic_req,
    input  logic [AW-1:0] ic_addr,
    output logic          ic_gnt,
    output logic          ic_rvalid,
    output logic [DW-1:0] ic_rdata,
    output logic          ic_done,
    input  logic          dc_req,
    input  logic          dc_we,
    input  logic [AW-1:0] dc_addr,
    input  logic [DW-1:0] dc_wdata,
    input  logic [3:0]    dc_be,
    output logic          dc_wnext,
    output logic          dc_gnt,
    output logic          dc_rvalid,
    output logic [DW-1:0] dc_rdata,
    output logic          dc_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_ic_bursts,
    output logic [31:0]   perf_dc_bursts,
    output logic [31:0]   perf_conflict_cycles
`endif
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [AW-1:0]     LINE_MASK = ~AW'(BURST_LEN - 1);

    arb_state_t        state;
    logic [BEAT_W-1:0] beat;
    logic [AW-1:0]     base_q;
    logic [3:0]        be_q;
    logic              cancel_q;

    logic              in_burst;
    logic              last_beat;
    logic              ic_cancel;

    // Arbitration only happens in IDLE and never while reset is applied.
    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .en     (state == IDLE && !rst),
        .ic_req (ic_req),
        .dc_req (dc_req),
        .ic_gnt (ic_gnt),
        .dc_gnt (dc_gnt)
    );

    assign in_burst  = (state != IDLE);
    assign last_beat = (beat == LAST_BEAT);
    // A flush on the current cycle already suppresses that cycle's beat.
    assign ic_cancel = cancel_q || flush;
    assign busy      = in_burst;

    // Bus-side and requester-side outputs derived from the current burst state.
    always_comb begin
        mem_req   = in_burst;
        mem_we    = (state == DC_WR);
        mem_addr  = in_burst ? (base_q + AW'(beat)) : '0;
        mem_wdata = (state == DC_WR) ? dc_wdata : '0;
        mem_be    = in_burst ? be_q : 4'h0;

        ic_rvalid = (state == IC_RD) && mem_ack && !ic_cancel;
        ic_rdata  = ic_rvalid ? mem_rdata : '0;
        ic_done   = ic_rvalid && last_beat;

        dc_rvalid = (state == DC_RD) && mem_ack;
        dc_rdata  = dc_rvalid ? mem_rdata : '0;
        dc_wnext  = (state == DC_WR) && mem_ack;
        dc_done   = (dc_rvalid || dc_wnext) && last_beat;
    end

    // Transaction FSM: latch the granted request, then step through the beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            base_q   <= '0;
            be_q     <= 4'h0;
            cancel_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cancel_q <= 1'b0;
                    beat     <= '0;
                    if (ic_gnt) begin
                        base_q <= ic_addr & LINE_MASK;
                        be_q   <= 4'hF;
                        state  <= IC_RD;
                    end else if (dc_gnt) begin
                        base_q <= dc_addr & LINE_MASK;
                        be_q   <= dc_we ? dc_be : 4'hF;
                        state  <= dc_we ? DC_WR : DC_RD;
                    end
                end
                default: begin
                    if (state == IC_RD && flush) begin
                        cancel_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        if (last_beat) begin
                            beat     <= '0;
                            cancel_q <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic conflict;

    assign conflict = (ic_req && !ic_gnt && (busy || dc_gnt)) ||
                      (dc_req && !dc_gnt && (busy || ic_gnt));

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ic_bursts       <= '0;
            perf_dc_bursts       <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (ic_done)  perf_ic_bursts       <= perf_ic_bursts + 32'd1;
            if (dc_done)  perf_dc_bursts       <= perf_dc_bursts + 32'd1;
            if (conflict) perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

    // Memory must only acknowledge an outstanding beat request.
    a_ack_needs_req: assert property (@(posedge clk) disable iff (rst)
        mem_ack |-> mem_req);

    // Requesters hold their request until granted.
    a_ic_req_held: assert property (@(posedge clk) disable iff (rst)
        (ic_req && !ic_gnt) |=> ic_req);

    a_dc_req_held: assert property (@(posedge clk) disable iff (rst)
        (dc_req && !dc_gnt) |=> dc_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with BURST_LEN=2, AW=30, DW=32.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ic_req;
    logic [29:0] ic_addr;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        ic_done;
    logic        dc_req;
    logic        dc_we;
    logic [29:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_be;
    logic        dc_wnext;
    logic        dc_gnt;
    logic        dc_rvalid;
    logic [31:0] dc_rdata;
    logic        dc_done;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int wn;

    always #5 clk = ~clk;

    mem_port_arbiter #(.BURST_LEN(2), .AW(30), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_gnt    (ic_gnt),
        .ic_rvalid (ic_rvalid),
        .ic_rdata  (ic_rdata),
        .ic_done   (ic_done),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_be     (dc_be),
        .dc_wnext  (dc_wnext),
        .dc_gnt    (dc_gnt),
        .dc_rvalid (dc_rvalid),
        .dc_rdata  (dc_rdata),
        .dc_done   (dc_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0; dc_be = 4'h0;
        mem_ack = 1'b0; mem_rdata = '0;

        // ---- reset: outputs quiet, request held off while reset is high
        cyc(); cyc();
        ic_req = 1'b1; ic_addr = 30'h105;
        #1;
        chk("rst_ic_gnt", ic_gnt, 0);
        chk("rst_dc_gnt", dc_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_dc_wnext", dc_wnext, 0);

        // ---- single IC refill at 0x105
        cyc(); rst = 1'b0; #1;
        chk("t1_gnt", ic_gnt, 1);
        chk("t1_gnt_memreq", mem_req, 0);
        cyc(); ic_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA000_0001; #1;
        chk("t1_b0_addr", mem_addr, 30'h104);
        chk("t1_b0_we", mem_we, 0);
        chk("t1_b0_be", mem_be, 4'hF);
        chk("t1_b0_rvalid", ic_rvalid, 1);
        chk("t1_b0_rdata", ic_rdata, 32'hA000_0001);
        chk("t1_b0_done", ic_done, 0);
        chk("t1_b0_busy", busy, 1);
        cyc(); mem_rdata = 32'hA000_0002; #1;
        chk("t1_b1_addr", mem_addr, 30'h105);
        chk("t1_b1_rvalid", ic_rvalid, 1);
        chk("t1_b1_rdata", ic_rdata, 32'hA000_0002);
        chk("t1_b1_done", ic_done, 1);
        chk("t1_b1_dc_rvalid", dc_rvalid, 0);
        cyc(); mem_ack = 1'b0; #1;
        chk("t1_end_busy", busy, 0);
        chk("t1_end_memreq", mem_req, 0);

        // ---- collision from reset: IC first, DC next, IC again
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; ic_req = 1'b1; ic_addr = 30'h10; dc_req = 1'b1; dc_addr = 30'h20; dc_we = 1'b0;
        #1;
        chk("t2_tie_ic_gnt", ic_gnt, 1);
        chk("t2_tie_dc_gnt", dc_gnt, 0);
        cyc(); ic_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hB000_0000; #1;
        chk("t2_wait_dc_gnt", dc_gnt, 0);
        chk("t2_ic_b0_addr", mem_addr, 30'h10);
        cyc(); mem_rdata = 32'hB000_0001; #1;
        chk("t2_ic_done", ic_done, 1);
        chk("t2_wait2_dc_gnt", dc_gnt, 0);
        cyc(); mem_ack = 1'b0; #1;
        chk("t2_dc_gnt", dc_gnt, 1);
        chk("t2_gap_memreq", mem_req, 0);
        cyc(); dc_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hC000_0000; #1;
        chk("t2_dc_b0_addr", mem_addr, 30'h20);
        chk("t2_dc_b0_rvalid", dc_rvalid, 1);
        chk("t2_dc_b0_rdata", dc_rdata, 32'hC000_0000);
        chk("t2_dc_b0_ic_rvalid", ic_rvalid, 0);
        cyc(); mem_rdata = 32'hC000_0001; #1;
        chk("t2_dc_b1_addr", mem_addr, 30'h21);
        chk("t2_dc_done", dc_done, 1);
        cyc(); mem_ack = 1'b0; ic_req = 1'b1; dc_req = 1'b1; #1;
        chk("t2_tie2_ic_gnt", ic_gnt, 1);
        chk("t2_tie2_dc_gnt", dc_gnt, 0);
        cyc(); ic_req = 1'b0; mem_ack = 1'b1; #1;
        chk("t2_ic2_b0_rvalid", ic_rvalid, 1);
        cyc(); #1;
        chk("t2_ic2_done", ic_done, 1);
        cyc(); mem_ack = 1'b0; #1;
        chk("t2_dc2_gnt", dc_gnt, 1);
        cyc(); dc_req = 1'b0; mem_ack = 1'b1; #1;
        cyc(); #1;
        chk("t2_dc2_done", dc_done, 1);
        cyc(); mem_ack = 1'b0;

        // ---- DC writeback at 0x40, be=0011, 3 stall cycles per beat
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 30'h40; dc_be = 4'b0011; dc_wdata = 32'h1111_0000;
        #1;
        chk("t3_gnt", dc_gnt, 1);
        wn = 0;
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 3; s++) begin
                cyc(); dc_req = 1'b0; mem_ack = 1'b0; dc_wdata = 32'h1111_0000 + b; #1;
                chk("t3_stall_we", mem_we, 1);
                chk("t3_stall_be", mem_be, 4'b0011);
                chk("t3_stall_addr", mem_addr, 30'h40 + b);
                chk("t3_stall_wdata", mem_wdata, 32'h1111_0000 + b);
                chk("t3_stall_wnext", dc_wnext, 0);
                if (dc_wnext) wn++;
            end
            cyc(); mem_ack = 1'b1; #1;
            chk("t3_ack_we", mem_we, 1);
            chk("t3_ack_be", mem_be, 4'b0011);
            chk("t3_ack_wnext", dc_wnext, 1);
            chk("t3_ack_done", dc_done, (b == 1));
            chk("t3_ack_rvalid", dc_rvalid, 0);
            if (dc_wnext) wn++;
        end
        cyc(); mem_ack = 1'b0; dc_we = 1'b0; #1;
        chk("t3_end_busy", busy, 0);
        chk("t3_wnext_count", wn, 2);

        // ---- flush after first IC beat
        ic_req = 1'b1; ic_addr = 30'h200; #1;
        chk("t4_gnt", ic_gnt, 1);
        cyc(); ic_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hD000_0000; #1;
        chk("t4_b0_rvalid", ic_rvalid, 1);
        cyc(); mem_ack = 1'b0; flush = 1'b1; #1;
        chk("t4_fl_rvalid", ic_rvalid, 0);
        chk("t4_fl_memreq", mem_req, 1);
        cyc(); flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hD000_0001; #1;
        chk("t4_b1_memreq", mem_req, 1);
        chk("t4_b1_addr", mem_addr, 30'h201);
        chk("t4_b1_rvalid", ic_rvalid, 0);
        chk("t4_b1_done", ic_done, 0);
        cyc(); mem_ack = 1'b0; #1;
        chk("t4_end_busy", busy, 0);

        // ---- flush on the exact final ack
        ic_req = 1'b1; ic_addr = 30'h300; #1;
        chk("t4b_gnt", ic_gnt, 1);
        cyc(); ic_req = 1'b0; mem_ack = 1'b1; #1;
        chk("t4b_b0_rvalid", ic_rvalid, 1);
        cyc(); flush = 1'b1; #1;
        chk("t4b_b1_rvalid", ic_rvalid, 0);
        chk("t4b_b1_done", ic_done, 0);
        chk("t4b_b1_memreq", mem_req, 1);
        cyc(); flush = 1'b0; mem_ack = 1'b0; #1;
        chk("t4b_end_busy", busy, 0);

        // ---- flush in IDLE has no effect on a new grant
        flush = 1'b1; ic_req = 1'b1; ic_addr = 30'h10; #1;
        chk("t4c_gnt", ic_gnt, 1);
        cyc(); flush = 1'b0; ic_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hE000_0000; #1;
        chk("t4c_b0_rvalid", ic_rvalid, 1);
        cyc(); #1;
        chk("t4c_b1_done", ic_done, 1);
        cyc(); mem_ack = 1'b0;

        // ---- reset mid DC_RD
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 30'h80; #1;
        chk("t5_gnt", dc_gnt, 1);
        cyc(); dc_req = 1'b0; mem_ack = 1'b1; #1;
        chk("t5_b0_rvalid", dc_rvalid, 1);
        cyc(); mem_ack = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        chk("t5_memreq", mem_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_dc_rvalid", dc_rvalid, 0);
        chk("t5_dc_done", dc_done, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_be", mem_be, 0);
        cyc(); ic_req = 1'b1; ic_addr = 30'h3FFF_FFFF; #1;
        chk("t5_ic_gnt", ic_gnt, 1);

        // ---- top-of-space base address, no wrap into 0
        cyc(); ic_req = 1'b0; mem_ack = 1'b1; #1;
        chk("t6_b0_addr", mem_addr, 30'h3FFF_FFFE);
        cyc(); #1;
        chk("t6_b1_addr", mem_addr, 30'h3FFF_FFFF);
        chk("t6_done", ic_done, 1);
        cyc(); mem_ack = 1'b0; #1;
        chk("t6_end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
